// File: rtl/dmem_bus_bridge_if.sv
// rtl/dmem_bus_bridge_if.sv - external peripheral req/ack bus between bridge and peripheral
interface dmem_bus_bridge_if;
  logic        ext_req;
  logic [29:0] ext_addr;
  logic [3:0]  ext_we;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;

  modport master (
    output ext_req,
    output ext_addr,
    output ext_we,
    output ext_wdata,
    input  ext_ack,
    input  ext_rdata
  );

  modport slave (
    input  ext_req,
    input  ext_addr,
    input  ext_we,
    input  ext_wdata,
    output ext_ack,
    output ext_rdata
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - routes core word accesses to local BRAM or a stalling req/ack peripheral port
module dmem_bus_bridge #(
  parameter int unsigned RAM_AW     = 12,
  parameter logic [3:0]  EXT_REGION = 4'hF,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [29:0]       mem_addr,
  input  logic [3:0]        mem_we,
  input  logic              mem_ce,
  input  logic [31:0]       mem_d,
  output logic [31:0]       mem_q,
  output logic              stall,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic              ram_ce,
  output logic [31:0]       ram_d,
  input  logic [31:0]       ram_q,
  dmem_bus_bridge_if.master ext,
  output logic              bus_err,
  input  logic              err_clr
);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ext_req_q, ext_req_d;
  logic [29:0] ext_addr_q, ext_addr_d;
  logic [3:0]  ext_we_q, ext_we_d;
  logic [31:0] ext_wdata_q, ext_wdata_d;
  logic [31:0] hold_q, hold_d;
  logic        q_sel_q, q_sel_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_ext;
  logic        stall_raw;
  logic        timeout_hit;

  assign is_ext   = (mem_addr[29:26] == EXT_REGION);
  assign ram_ce   = mem_ce & ~is_ext;
  assign ram_we   = ram_ce ? mem_we : 4'b0000;
  assign ram_addr = mem_addr[RAM_AW-1:0];
  assign ram_d    = mem_d;

  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req_q;
    ext_addr_d  = ext_addr_q;
    ext_we_d    = ext_we_q;
    ext_wdata_d = ext_wdata_q;
    hold_d      = hold_q;
    q_sel_d     = q_sel_q;
    cnt_d       = cnt_q;
    stall_raw   = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_ce && is_ext) begin
          stall_raw   = 1'b1;
          ext_req_d   = 1'b1;
          ext_addr_d  = mem_addr;
          ext_we_d    = mem_we;
          ext_wdata_d = mem_d;
          cnt_d       = 16'd0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q + 16'd1;
        // An ack arriving on the last allowed cycle still completes normally.
        if (ext.ext_ack) begin
          if (ext_we_q == 4'b0000) hold_d = ext.ext_rdata;
          ext_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          if (ext_we_q == 4'b0000) hold_d = ERR_DATA;
          ext_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (mem_ce && !stall_raw) q_sel_d = is_ext;

    bus_err_d = timeout_hit ? 1'b1 : (err_clr ? 1'b0 : bus_err_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ext_req_q   <= 1'b0;
      ext_addr_q  <= 30'd0;
      ext_we_q    <= 4'd0;
      ext_wdata_q <= 32'd0;
      hold_q      <= 32'd0;
      q_sel_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      ext_req_q   <= ext_req_d;
      ext_addr_q  <= ext_addr_d;
      ext_we_q    <= ext_we_d;
      ext_wdata_q <= ext_wdata_d;
      hold_q      <= hold_d;
      q_sel_q     <= q_sel_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Stall must fall with reset even if the core is still presenting an external request.
  assign stall         = stall_raw & reset_n;
  assign mem_q         = q_sel_q ? hold_q : ram_q;
  assign bus_err       = bus_err_q;
  assign ext.ext_req   = ext_req_q;
  assign ext.ext_addr  = ext_addr_q;
  assign ext.ext_we    = ext_we_q;
  assign ext.ext_wdata = ext_wdata_q;
endmodule
